// File: rtl/score_pkg.sv
// Shared encodings and constants for the score/display feeder.
// Also holds the leading-zero blanking helper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [15:0] BCD_MAX        = 16'h9999;
  localparam logic [3:0]  DISP_BLANK_ALL = 4'b1111;
  localparam logic [3:0]  HIGH_DP        = 4'b1000;

  // Bit N set blanks digit N; digit0 always stays visible.
  function automatic logic [3:0] lead_zero_blank(input logic [15:0] v);
    logic [3:0] b;
    b[3] = (v[15:12] == 4'd0);
    b[2] = b[3] && (v[11:8] == 4'd0);
    b[1] = b[2] && (v[7:4] == 4'd0);
    b[0] = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/bcd4_inc.sv
// Combinational 4-digit packed-BCD +1 that holds at 9999.
module bcd4_inc
  import score_pkg::*;
(
  input  logic [15:0] i_val,
  output logic [15:0] o_val,
  output logic        o_sat
);

  logic w_carry;

  always_comb begin
    o_sat   = (i_val == BCD_MAX);
    o_val   = i_val;
    w_carry = 1'b1;
    if (!o_sat) begin
      for (int d = 0; d < 4; d++) begin
        if (w_carry) begin
          // Any digit at 9 (or corrupt A-F) rolls to 0 and passes the carry on.
          if (i_val[d*4 +: 4] >= 4'd9) begin
            o_val[d*4 +: 4] = 4'd0;
          end else begin
            o_val[d*4 +: 4] = i_val[d*4 +: 4] + 4'd1;
            w_carry         = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Game-phase FSM, BCD score / high score, and the registered HEXS/LES/points
// words for the seven-segment display driver, with new-record blinking.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        score_inc,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        show_high,
  output logic [15:0] HEXS,
  output logic [3:0]  LES,
  output logic [3:0]  points
);

  localparam int CNT_W = $clog2(BLINK_HALF) + 1;

  state_t             r_state, w_next;
  logic [15:0]        r_score, r_high;
  logic               r_new_rec, r_inc_q;
  logic [CNT_W-1:0]   r_blink_cnt;
  logic               r_blink_off;

  logic               w_inc_pulse, w_sat, w_enter_play;
  logic [15:0]        w_score_nxt, w_final;
  logic               w_src_high, w_blink_act;
  logic [15:0]        w_disp_hexs;
  logic [3:0]         w_disp_les, w_disp_pts;

  bcd4_inc u_inc (
    .i_val (r_score),
    .o_val (w_score_nxt),
    .o_sat (w_sat)
  );

  assign w_inc_pulse  = score_inc & ~r_inc_q;
  // The final score at game end includes an increment taken on the same edge.
  assign w_final      = (w_inc_pulse && !w_sat) ? w_score_nxt : r_score;
  assign w_enter_play = (w_next == PLAY) && (r_state != PLAY);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (game_start) w_next = PLAY;
      PLAY:    if (game_over)  w_next = OVER;
      OVER:    if (game_start) w_next = PLAY;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_src_high  = ((r_state == IDLE || r_state == OVER) && show_high) ||
                  (r_state == IDLE && r_high == 16'h0000);
    w_blink_act = (r_state == OVER) && r_new_rec && !w_src_high;
    w_disp_hexs = w_src_high ? r_high : r_score;
    w_disp_pts  = w_src_high ? HIGH_DP : 4'b0000;
    w_disp_les  = (w_blink_act && r_blink_off) ? DISP_BLANK_ALL
                                               : lead_zero_blank(w_disp_hexs);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_score   <= 16'h0000;
      r_high    <= 16'h0000;
      r_new_rec <= 1'b0;
      r_inc_q   <= 1'b0;
    end else begin
      r_inc_q <= score_inc;
      if (w_enter_play) begin
        r_score   <= 16'h0000;
        r_new_rec <= 1'b0;
      end else if (r_state == PLAY) begin
        r_score <= w_final;
        // Packed BCD compares correctly as a plain unsigned value.
        if (w_next == OVER && w_final > r_high) begin
          r_high    <= w_final;
          r_new_rec <= 1'b1;
        end
      end
    end
  end

  // Blink timer restarts on-phase whenever blinking is not active.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (!w_blink_act) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      HEXS   <= 16'h0000;
      LES    <= 4'b1110;
      points <= 4'b0000;
    end else begin
      HEXS   <= w_disp_hexs;
      LES    <= w_disp_les;
      points <= w_disp_pts;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl with a short blink period.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        score_inc = 1'b0;
  logic        game_start = 1'b0;
  logic        game_over = 1'b0;
  logic        show_high = 1'b0;
  logic [15:0] HEXS;
  logic [3:0]  LES;
  logic [3:0]  points;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] hexs;
    logic [3:0]  les;
    logic [3:0]  pts;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  score_display_ctrl #(.BLINK_HALF(4)) dut (
    .clk        (clk),
    .RST        (RST),
    .score_inc  (score_inc),
    .game_start (game_start),
    .game_over  (game_over),
    .show_high  (show_high),
    .HEXS       (HEXS),
    .LES        (LES),
    .points     (points)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1; tick();
      score_inc = 1'b0; tick();
    end
  endtask

  task automatic start_game();
    game_start = 1'b1; tick();
    game_start = 1'b0; tick();
  endtask

  task automatic end_game();
    game_over = 1'b1; tick();
    game_over = 1'b0;
  endtask

  task automatic test_reset();
    #3 RST = 1'b1;
    #1;
    sbq.push_back('{name:"rst_hold", hexs:16'h0000, les:4'b1110, pts:4'b0000});
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    tick(); #2 RST = 1'b0; #1;
    sbq.push_back('{name:"rst_release", hexs:16'h0000, les:4'b1110, pts:4'b0000});
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    // IDLE with an empty high score presents the high score.
    sbq.push_back('{name:"idle_high0", hexs:16'h0000, les:4'b1110, pts:4'b1000});
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    start_game();
    sbq.push_back('{name:"pre_rst_0042", hexs:16'h0042, les:4'b1100, pts:4'b0000});
    pulse_inc(42);
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    sbq.push_back('{name:"rst_async_play", hexs:16'h0000, les:4'b1110, pts:4'b0000});
    #2 RST = 1'b1;
    #1;
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    tick(); #2 RST = 1'b0;
    tick();
  endtask

  task automatic test_counting();
    start_game();
    sbq.push_back('{name:"count_0012", hexs:16'h0012, les:4'b1100, pts:4'b0000});
    pulse_inc(12);
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    sbq.push_back('{name:"hold_one_inc", hexs:16'h0013, les:4'b1100, pts:4'b0000});
    score_inc = 1'b1;
    repeat (50) tick();
    score_inc = 1'b0;
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    sbq.push_back('{name:"start_in_play", hexs:16'h0013, les:4'b1100, pts:4'b0000});
    start_game();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
  endtask

  task automatic test_carry();
    end_game(); tick();
    sbq.push_back('{name:"new_game_0000", hexs:16'h0000, les:4'b1110, pts:4'b0000});
    start_game();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    sbq.push_back('{name:"carry_0099", hexs:16'h0099, les:4'b1100, pts:4'b0000});
    sbq.push_back('{name:"carry_0100", hexs:16'h0100, les:4'b1000, pts:4'b0000});
    pulse_inc(99);
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    pulse_inc(1);
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    end_game(); tick();
    start_game();
    sbq.push_back('{name:"sat_9998", hexs:16'h9998, les:4'b0000, pts:4'b0000});
    sbq.push_back('{name:"sat_9999", hexs:16'h9999, les:4'b0000, pts:4'b0000});
    pulse_inc(9998);
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    pulse_inc(3);
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    #2 RST = 1'b1;
    tick(); #2 RST = 1'b0;
    tick();
  endtask

  task automatic test_record();
    start_game();
    pulse_inc(7);
    end_game();
    for (int i = 0; i < 16; i++)
      sbq.push_back('{name:"blink", hexs:16'h0007,
                      les:(((i / 4) % 2) != 0) ? 4'b1111 : 4'b1110, pts:4'b0000});
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sbq.pop_front(); n_cmp++;
      if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
        n_err++;
        $display("FAIL %s[%0d]: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
                 e.name, i, HEXS, LES, points, e.hexs, e.les, e.pts);
      end
    end
    show_high = 1'b1;
    for (int i = 0; i < 3; i++)
      sbq.push_back('{name:"show_high_steady", hexs:16'h0007, les:4'b1110, pts:4'b1000});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sbq.pop_front(); n_cmp++;
      if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
        n_err++;
        $display("FAIL %s[%0d]: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
                 e.name, i, HEXS, LES, points, e.hexs, e.les, e.pts);
      end
    end
    show_high = 1'b0;
    for (int i = 0; i < 5; i++)
      sbq.push_back('{name:"blink_restart", hexs:16'h0007,
                      les:(i == 4) ? 4'b1111 : 4'b1110, pts:4'b0000});
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sbq.pop_front(); n_cmp++;
      if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
        n_err++;
        $display("FAIL %s[%0d]: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
                 e.name, i, HEXS, LES, points, e.hexs, e.les, e.pts);
      end
    end
  endtask

  task automatic test_no_record();
    for (int g = 0; g < 2; g++) begin
      start_game();
      pulse_inc((g == 0) ? 5 : 7);
      end_game();
      for (int i = 0; i < 10; i++)
        sbq.push_back('{name:(g == 0) ? "lower_no_blink" : "equal_no_blink",
                        hexs:(g == 0) ? 16'h0005 : 16'h0007, les:4'b1110, pts:4'b0000});
      for (int i = 0; i < 10; i++) begin
        tick();
        e = sbq.pop_front(); n_cmp++;
        if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
          n_err++;
          $display("FAIL %s[%0d]: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
                   e.name, i, HEXS, LES, points, e.hexs, e.les, e.pts);
        end
      end
    end
    show_high = 1'b1;
    sbq.push_back('{name:"high_kept_0007", hexs:16'h0007, les:4'b1110, pts:4'b1000});
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    show_high = 1'b0;
  endtask

  task automatic test_simultaneous();
    start_game();
    pulse_inc(9);
    score_inc = 1'b1; game_over = 1'b1; tick();
    score_inc = 1'b0; game_over = 1'b0;
    sbq.push_back('{name:"inc_with_over", hexs:16'h0010, les:4'b1100, pts:4'b0000});
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    show_high = 1'b1;
    sbq.push_back('{name:"high_0010", hexs:16'h0010, les:4'b1100, pts:4'b1000});
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    show_high = 1'b0;
    start_game();
    pulse_inc(3);
    game_start = 1'b1; game_over = 1'b1; tick();
    game_start = 1'b0; game_over = 1'b0;
    sbq.push_back('{name:"start_over_score", hexs:16'h0003, les:4'b1110, pts:4'b0000});
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    show_high = 1'b1;
    sbq.push_back('{name:"start_over_in_over", hexs:16'h0010, les:4'b1100, pts:4'b1000});
    tick();
    e = sbq.pop_front(); n_cmp++;
    if ({HEXS, LES, points} !== {e.hexs, e.les, e.pts}) begin
      n_err++;
      $display("FAIL %s: got HEXS=%h LES=%b points=%b, want HEXS=%h LES=%b points=%b",
               e.name, HEXS, LES, points, e.hexs, e.les, e.pts);
    end
    show_high = 1'b0;
  endtask

  initial begin
    test_reset();
    test_counting();
    test_carry();
    test_record();
    test_no_record();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Upstream feeder of the 4-digit seven-segment display driver in the flappy-bird design.
- Keeps the current game score as 4-digit packed BCD and a session high score.
- Tracks game phase (idle/play/over) and produces the HEXS/LES/points words the display stage consumes.
- Handles leading-zero blanking, high-score indication and new-record blinking.

Parameters:
- BLINK_HALF, 25000000: clk cycles per half-period of the new-record blink (0.25 s at 100 MHz); minimum 1.
- CNT_W, $clog2(BLINK_HALF)+1: width of the blink counter (derived localparam, not overridable).

Ports:
- clk  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- score_inc  in  1  score request from game logic; one increment per rising edge
- game_start  in  1  start a new game
- game_over  in  1  end the current game
- show_high  in  1  level; shows the high score while in IDLE or OVER
- HEXS  out  16  four packed BCD digits, [15:12]=digit3 (MSD) … [3:0]=digit0
- LES  out  4  per-digit blank request, 1 = digit blanked
- points  out  4  per-digit decimal-point request, 1 = DP lit

Behaviour:
- All outputs and state registered. Async reset gives:
  - state=IDLE; score=0000; high=0000; new_rec=0; blink counter=0; blink phase=on
  - HEXS=16'h0000, LES=4'b1110, points=4'b0000
- Reset mid-game discards score and high score.
- States (2-bit encoding from package): IDLE=0, PLAY=1, OVER=2; 3 is illegal and returns to IDLE.
- Transitions:
  - IDLE --game_start--> PLAY
  - PLAY --game_over--> OVER
  - OVER --game_start--> PLAY
  - game_start while in PLAY is ignored.
  - game_start and game_over in the same cycle while in PLAY: game_over wins.
- Entering PLAY clears score to 0000 and new_rec to 0 on the same edge.
- score_inc:
  - Registered once; an increment occurs the cycle after a 0→1 transition is seen (inc_pulse = score_inc & ~score_inc_q).
  - Counted only while in PLAY.
  - Held high gives exactly one increment.
- BCD increment:
  - digit0 +1; digit0 at 9 wraps to 0 and carries up.
  - Saturates at 9999: an increment at 9999 leaves 9999.
  - No digit ever holds A–F.
- Game end:
  - On the PLAY→OVER edge, compare the final score including any increment taken that same cycle.
  - If final score > high (unsigned BCD compare, MSD first), high := final score and new_rec := 1.
  - Equal score does not set new_rec.
- Display source:
  - Shows high when (state==IDLE or OVER) and show_high==1, or when state==IDLE with high==0000.
  - Otherwise shows score.
- Display word:
  - HEXS = source value.
  - LES blanks leading zeros. Digit0 is never blanked. digitN (N≥1) is blanked iff it and all higher digits are 0. Examples: 0000→1110, 0042→1100, 0307→1000.
  - points = 4'b1000 while the high score is the source, else 4'b0000.
- Blink:
  - Active only in OVER with new_rec=1 and score as the source.
  - Counter runs 0..BLINK_HALF-1, then toggles phase and wraps to 0.
  - During the off phase, LES=4'b1111 (points unaffected).
  - Counter and phase reset to 0/on whenever blink is inactive, so blink always starts with a full on-half.
- Output latency: HEXS/LES/points reflect the state/score of the previous edge (one-cycle register stage).

Decomposition:
- Package score_pkg:
  - state encodings IDLE/PLAY/OVER
  - BCD_MAX = 16'h9999
  - DISP_BLANK_ALL = 4'b1111
  - HIGH_DP = 4'b1000
- Sub-module bcd4_inc:
  - combinational 4-digit BCD +1 with saturation flag
  - instantiated once, for the score register

Test Plan:
- Reset check: assert RST mid-cycle, release → HEXS=0000, LES=1110, points=0000, state IDLE. RST asserted during PLAY with score 0042 → same values immediately, without a clock edge.
- Basic counting and edge detection:
  - game_start, then 12 score_inc pulses → HEXS=0012, LES=1100.
  - Hold score_inc high 50 cycles → exactly one increment (0013).
- Carry and saturation:
  - 99 pulses → 0099, LES=1100; one more pulse → 0100, LES=1000.
  - Preload to 9998 via pulses, 3 more pulses → 9999, LES=0000.
- New record and blink (BLINK_HALF=4):
  - Score 0007, game_over (high was 0000) → high=0007, new_rec=1.
  - LES alternates 1110 for 4 cycles, then 1111 for 4 cycles, repeating.
  - show_high=1 → HEXS=0007, points=1000, blinking stops.
- Non-record game:
  - Score 0005 with high 0007, game_over → high stays 0007, LES steady 1110, no blink.
  - Score equal to high (0007) → still no blink.
- Simultaneous events:
  - In PLAY at score 0009, assert score_inc edge and game_over together → final 0010 stored as high (if greater), state OVER.
  - game_start+game_over together in PLAY → OVER.
